// File: rtl/fifo_wr_arbiter.sv
// Round-robin write arbiter: two valid/ready producers share one fifo_generic write port,
// each grant lasting up to BURST_LEN words, with full-stall and fair alternation.
module fifo_wr_arbiter #(
  parameter int FIFO_DATA_WIDTH = 8,
  parameter int BURST_LEN       = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       src0_valid,
  input  logic [FIFO_DATA_WIDTH-1:0] src0_data,
  output logic                       src0_ready,
  input  logic                       src1_valid,
  input  logic [FIFO_DATA_WIDTH-1:0] src1_data,
  output logic                       src1_ready,
  input  logic                       full,
  output logic                       write,
  output logic [FIFO_DATA_WIDTH-1:0] write_data,
  output logic [1:0]                 grant,
  output logic                       busy
);

  localparam int CW = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
  localparam logic [CW-1:0] LAST_BEAT = CW'(BURST_LEN - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    GRANT0 = 2'd1,
    GRANT1 = 2'd2
  } state_e;

  state_e        state_q, state_d;
  logic          last_q, last_d;
  logic [CW-1:0] burst_cnt_q, burst_cnt_d;

  logic                       sel;
  logic                       own_valid;
  logic                       oth_valid;
  logic [FIFO_DATA_WIDTH-1:0] own_data;
  logic                       xfer;
  logic                       enter;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      last_q      <= 1'b1;
      burst_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      last_q      <= last_d;
      burst_cnt_q <= burst_cnt_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    last_d      = last_q;
    burst_cnt_d = burst_cnt_q;
    enter       = 1'b0;
    sel         = (state_q == GRANT1);
    own_valid   = sel ? src1_valid : src0_valid;
    oth_valid   = sel ? src0_valid : src1_valid;
    own_data    = sel ? src1_data  : src0_data;
    xfer        = 1'b0;
    src0_ready  = 1'b0;
    src1_ready  = 1'b0;
    write       = 1'b0;
    write_data  = '0;
    grant       = 2'b00;
    busy        = 1'b0;

    case (state_q)
      IDLE: begin
        if (src0_valid && src1_valid) begin
          state_d = last_q ? GRANT0 : GRANT1;
          enter   = 1'b1;
        end else if (src0_valid) begin
          state_d = GRANT0;
          enter   = 1'b1;
        end else if (src1_valid) begin
          state_d = GRANT1;
          enter   = 1'b1;
        end
      end
      GRANT0, GRANT1: begin
        if (sel) src1_ready = !full;
        else     src0_ready = !full;
        write      = own_valid && !full;
        write_data = own_data;
        grant[sel] = 1'b1;
        busy       = 1'b1;
        xfer       = own_valid && !full;
        // A full cycle never ends the burst, even if the owner's valid is low.
        if (!full && (!own_valid || (xfer && burst_cnt_q == LAST_BEAT))) begin
          if (oth_valid) begin
            state_d = sel ? GRANT0 : GRANT1;
            enter   = 1'b1;
          end else if (own_valid) begin
            state_d = state_q;
            enter   = 1'b1;
          end else begin
            state_d = IDLE;
          end
        end else if (xfer) begin
          burst_cnt_d = burst_cnt_q + CW'(1);
        end
      end
      default: state_d = IDLE;
    endcase

    if (enter) begin
      burst_cnt_d = '0;
      last_d      = (state_d == GRANT1);
    end

    if (reset) begin
      src0_ready = 1'b0;
      src1_ready = 1'b0;
      write      = 1'b0;
      write_data = '0;
      grant      = 2'b00;
      busy       = 1'b0;
    end
  end

endmodule
